alu_arbiter: RTL and testbench

Shares a single tinyalu between two requesters (port 0 and port 1, e.g. the instruction unit and a second execution client). It arbitrates round-robin, latches the winner's operands, and drives the tinyalu start/done handshake. It returns the 16-bit result to the granted port, and aborts with an error if the ALU does not finish within a watchdog limit. It sits between the requesters and the tinyalu instance; the tinyalu opcodes are the `alu_opcode_t` type from `tinyalu_pkg`.

---
 rtl/alu_arbiter.sv | 174 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one tinyalu between two requesters, with a
// start/done handshake toward the ALU and a watchdog abort for hung operations.

package tinyalu_pkg;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    rst_op = 3'b111
  } alu_opcode_t;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    alu_opcode_t op;
  } alu_req_t;

endpackage

module alu_arbiter
  import tinyalu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  rq_start,
  input  logic [7:0]  rq_A0,
  input  logic [7:0]  rq_B0,
  input  alu_opcode_t rq_op0,
  input  logic [7:0]  rq_A1,
  input  logic [7:0]  rq_B1,
  input  alu_opcode_t rq_op1,
  output logic [1:0]  rq_done,
  output logic [1:0]  rq_err,
  output logic [15:0] rq_result0,
  output logic [15:0] rq_result1,
  output logic        alu_start,
  output logic [7:0]  alu_A,
  output logic [7:0]  alu_B,
  output alu_opcode_t alu_op,
  input  logic [15:0] alu_result,
  input  logic        alu_done,
  output logic        busy,
  output logic        grant
);

  localparam int unsigned TIMER_W = 8;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 last_grant_q, last_grant_d;
  logic                 grant_q, grant_d;
  logic                 alu_start_q, alu_start_d;
  logic                 busy_q, busy_d;
  alu_req_t             req_q, req_d;
  logic [1:0]           rq_done_q, rq_done_d;
  logic [1:0]           rq_err_q, rq_err_d;
  logic [15:0]          res0_q, res0_d;
  logic [15:0]          res1_q, res1_d;
  logic                 win;

  // Next-state and next-output logic; every output is the registered copy.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    alu_start_d  = alu_start_q;
    busy_d       = busy_q;
    req_d        = req_q;
    rq_done_d    = 2'b00;
    rq_err_d     = 2'b00;
    res0_d       = res0_q;
    res1_d       = res1_q;
    win          = 1'b0;

    case (state_q)
      IDLE: begin
        if (rq_start != 2'b00) begin
          // On a tie the port that was not served last goes first.
          win          = (rq_start == 2'b11) ? ~last_grant_q : rq_start[1];
          req_d        = win ? '{a: rq_A1, b: rq_B1, op: rq_op1}
                             : '{a: rq_A0, b: rq_B0, op: rq_op0};
          grant_d      = win;
          last_grant_d = win;
          timer_d      = '0;
          alu_start_d  = 1'b1;
          busy_d       = 1'b1;
          state_d      = BUSY;
        end
      end

      BUSY: begin
        timer_d = timer_q + TIMER_W'(1);
        if (alu_done) begin
          if (grant_q) res1_d = alu_result;
          else         res0_d = alu_result;
          rq_done_d[grant_q] = 1'b1;
          alu_start_d        = 1'b0;
          state_d            = RESP;
        end else if (timer_q == TIMER_LAST) begin
          if (grant_q) res1_d = 16'h0000;
          else         res0_d = 16'h0000;
          rq_done_d[grant_q] = 1'b1;
          rq_err_d[grant_q]  = 1'b1;
          alu_start_d        = 1'b0;
          state_d            = RESP;
        end
      end

      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        alu_start_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      alu_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      req_q        <= '{a: 8'h00, b: 8'h00, op: no_op};
      rq_done_q    <= 2'b00;
      rq_err_q     <= 2'b00;
      res0_q       <= 16'h0000;
      res1_q       <= 16'h0000;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      alu_start_q  <= alu_start_d;
      busy_q       <= busy_d;
      req_q        <= req_d;
      rq_done_q    <= rq_done_d;
      rq_err_q     <= rq_err_d;
      res0_q       <= res0_d;
      res1_q       <= res1_d;
    end
  end

  assign rq_done    = rq_done_q;
  assign rq_err     = rq_err_q;
  assign rq_result0 = res0_q;
  assign rq_result1 = res1_q;
  assign alu_start  = alu_start_q;
  assign alu_A      = req_q.a;
  assign alu_B      = req_q.b;
  assign alu_op     = req_q.op;
  assign busy       = busy_q;
  assign grant      = grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter: a stub tinyalu with programmable
// latency, a round-robin order model, and a decoupled completion monitor.

module tb_alu_arbiter;
  import tinyalu_pkg::*;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  rq_start;
  logic [7:0]  rq_A0, rq_B0, rq_A1, rq_B1;
  alu_opcode_t rq_op0, rq_op1;
  logic [1:0]  rq_done, rq_err;
  logic [15:0] rq_result0, rq_result1;
  logic        alu_start;
  logic [7:0]  alu_A, alu_B;
  alu_opcode_t alu_op;
  logic [15:0] alu_result;
  logic        alu_done;
  logic        busy, grant;

  alu_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .rq_start(rq_start),
    .rq_A0(rq_A0), .rq_B0(rq_B0), .rq_op0(rq_op0),
    .rq_A1(rq_A1), .rq_B1(rq_B1), .rq_op1(rq_op1),
    .rq_done(rq_done), .rq_err(rq_err),
    .rq_result0(rq_result0), .rq_result1(rq_result1),
    .alu_start(alu_start), .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_result(alu_result), .alu_done(alu_done),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic        err;
    logic [15:0] res;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] res_model [2];
  logic        lg_model;

  // ALU stub controls
  int          alu_lat = 1;
  int          scnt = 0;
  bit          use_force = 0;
  logic [15:0] force_res = 16'h0;
  bit          spur_req = 0;

  function automatic logic [15:0] ref_alu(alu_opcode_t op, logic [7:0] a, logic [7:0] b);
    case (op)
      add_op:  return 16'(a) + 16'(b);
      and_op:  return {8'h00, a & b};
      xor_op:  return {8'h00, a ^ b};
      mul_op:  return 16'(a) * 16'(b);
      rst_op:  return {b, a};
      default: return {a, b};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stub tinyalu: done after alu_lat cycles of alu_start (0 = never), optional stray done when idle.
  always @(negedge clk) begin
    if (alu_start) begin
      scnt++;
      alu_done = (alu_lat != 0) && (scnt == alu_lat);
      alu_result = alu_done ? (use_force ? force_res : ref_alu(alu_op, alu_A, alu_B))
                            : 16'($urandom);
    end else begin
      scnt = 0;
      alu_done = spur_req;
      alu_result = 16'($urandom);
      spur_req = 0;
    end
  end

  // Monitor: pops one expectation per completion pulse.
  initial begin : monitor
    int   start_cnt;
    exp_t e;
    start_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) start_cnt = 0;
      else if (alu_start) start_cnt++;
      if (reset_n && rq_done != 2'b00) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(rq_done), 32'h0);
        end else begin
          e = sb.pop_front();
          chk("done_port", 32'(rq_done), 32'(2'b01 << e.port));
          chk("err", 32'(rq_err), e.err ? 32'(2'b01 << e.port) : 32'h0);
          chk("grant", 32'(grant), 32'(e.port));
          chk("start_cycles", 32'(start_cnt), 32'(e.cycles));
          chk("start_low_in_resp", 32'(alu_start), 32'h0);
          chk("busy_in_resp", 32'(busy), 32'h1);
          res_model[e.port] = e.res;
          chk("result0", 32'(rq_result0), 32'(res_model[0]));
          chk("result1", 32'(rq_result1), 32'(res_model[1]));
        end
        start_cnt = 0;
      end
    end
  end

  function automatic exp_t mk_exp(int port, alu_opcode_t op, logic [7:0] a, logic [7:0] b,
                                  int lat, bit frc, logic [15:0] fres);
    exp_t e;
    e.port   = port;
    e.err    = (lat == 0) || (lat > int'(TO));
    e.res    = e.err ? 16'h0000 : (frc ? fres : ref_alu(op, a, b));
    e.cycles = e.err ? int'(TO) : lat;
    return e;
  endfunction

  task automatic run_txn(input logic [1:0] mask, input bit stagger,
                         input alu_opcode_t op0, input logic [7:0] a0, input logic [7:0] b0,
                         input alu_opcode_t op1, input logic [7:0] a1, input logic [7:0] b1,
                         input int lat, input bit frc, input logic [15:0] fres);
    logic [1:0] pending;
    int first, budget;
    alu_lat = lat; use_force = frc; force_res = fres;
    rq_A0 = a0; rq_B0 = b0; rq_op0 = op0;
    rq_A1 = a1; rq_B1 = b1; rq_op1 = op1;
    if (mask == 2'b11) begin
      first = stagger ? 0 : (lg_model ? 0 : 1);
      sb.push_back(mk_exp(first, first ? op1 : op0, first ? a1 : a0, first ? b1 : b0, lat, frc, fres));
      sb.push_back(mk_exp(1 - first, first ? op0 : op1, first ? a0 : a1, first ? b0 : b1, lat, frc, fres));
      lg_model = (first == 0);
    end else begin
      first = mask[1] ? 1 : 0;
      sb.push_back(mk_exp(first, first ? op1 : op0, first ? a1 : a0, first ? b1 : b0, lat, frc, fres));
      lg_model = mask[1];
    end
    if (mask == 2'b11 && stagger) begin
      rq_start = 2'b01;
      @(negedge clk);
      rq_start = 2'b11;
    end else begin
      rq_start = mask;
    end
    pending = mask;
    budget = 0;
    while (pending != 2'b00 && budget < 200) begin
      @(negedge clk);
      budget++;
      for (int i = 0; i < 2; i++)
        if (pending[i] && rq_done[i]) begin
          pending[i] = 1'b0;
          rq_start[i] = 1'b0;
        end
    end
    if (pending != 2'b00) begin
      chk("done_timeout", 32'(pending), 32'h0);
      rq_start = 2'b00;
    end
    @(negedge clk);
    chk("idle_after", 32'(busy), 32'h0);
    use_force = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_done"}, 32'(rq_done), 32'h0);
    chk({tag, "_err"}, 32'(rq_err), 32'h0);
    chk({tag, "_res0"}, 32'(rq_result0), 32'h0);
    chk({tag, "_res1"}, 32'(rq_result1), 32'h0);
    chk({tag, "_start"}, 32'(alu_start), 32'h0);
    chk({tag, "_A"}, 32'(alu_A), 32'h0);
    chk({tag, "_B"}, 32'(alu_B), 32'h0);
    chk({tag, "_op"}, 32'(alu_op), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

  alu_opcode_t ops [6] = '{no_op, add_op, and_op, xor_op, mul_op, rst_op};

  initial begin : driver
    int cnt;
    reset_n = 1'b0;
    rq_start = 2'b00;
    rq_A0 = 8'h00; rq_B0 = 8'h00; rq_op0 = no_op;
    rq_A1 = 8'h00; rq_B1 = 8'h00; rq_op1 = no_op;
    res_model[0] = 16'h0; res_model[1] = 16'h0;
    lg_model = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    run_txn(2'b01, 0, add_op, 8'h05, 8'h03, no_op, 8'h00, 8'h00, 1, 0, 16'h0);
    run_txn(2'b11, 0, and_op, 8'hF0, 8'h3C, xor_op, 8'hF0, 8'h3C, 1, 0, 16'h0);
    run_txn(2'b11, 0, and_op, 8'hF0, 8'h3C, xor_op, 8'hF0, 8'h3C, 2, 0, 16'h0);
    run_txn(2'b10, 0, add_op, 8'h11, 8'h22, mul_op, 8'hFF, 8'hFF, 3, 0, 16'h0);
    run_txn(2'b01, 0, add_op, 8'h44, 8'h55, no_op, 8'h00, 8'h00, 0, 0, 16'h0);
    run_txn(2'b01, 0, xor_op, 8'h0F, 8'hFF, no_op, 8'h00, 8'h00, 2, 0, 16'h0);
    run_txn(2'b01, 0, add_op, 8'h01, 8'h02, no_op, 8'h00, 8'h00, int'(TO), 1, 16'h1234);
    run_txn(2'b10, 0, no_op, 8'h00, 8'h00, rst_op, 8'hA5, 8'h5A, 1, 0, 16'h0);
    run_txn(2'b11, 1, add_op, 8'h10, 8'h20, and_op, 8'h77, 8'h0F, 4, 0, 16'h0);

    // Reset in the second BUSY cycle abandons the operation silently.
    alu_lat = 0;
    rq_A0 = 8'h09; rq_B0 = 8'h09; rq_op0 = add_op;
    rq_start = 2'b01;
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 2; i++) begin
      @(negedge clk);
      if (alu_start) cnt++;
    end
    chk("reset_mid_reached_busy2", 32'(cnt), 32'd2);
    reset_n = 1'b0;
    rq_start = 2'b00;
    @(negedge clk);
    chk_all_zero("midreset");
    lg_model = 1'b1;
    res_model[0] = 16'h0; res_model[1] = 16'h0;
    reset_n = 1'b1;
    @(negedge clk);
    run_txn(2'b01, 0, add_op, 8'h01, 8'h01, no_op, 8'h00, 8'h00, 1, 0, 16'h0);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] m;
      m = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) begin
        spur_req = 1;
        repeat (2) @(negedge clk);
      end
      run_txn(m, bit'($urandom_range(0, 1)),
              ops[$urandom_range(0, 5)], 8'($urandom), 8'($urandom),
              ops[$urandom_range(0, 5)], 8'($urandom), 8'($urandom),
              $urandom_range(0, 10), 0, 16'h0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
